bcd_timer_core: RTL and testbench
=================================

# bcd_timer_core

Parametrised MM:SS timer core that replaces the fixed minutes counter and its separate control state machine with one block. It holds four BCD digits, counts up or down at one step per second derived from the system clock, supports pause/resume and manual preset, and flags completion. Digit outputs feed the VGA text writer unchanged. Button inputs are debounced, synchronous levels on `clk`.

## Interface
- `CYCLES_PER_SEC`, 50_000_000: clock cycles per one-second step; ≥2. Use 4 in simulation.
- `MAX_MIN`, 99: highest minutes value, 1..99. Up-count target is MAX_MIN:59; the minutes preset wraps above it.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high. Returns the block to IDLE, 00:00, with all outputs 0.
- `start`  in  1  level; a rising edge starts or resumes counting.
- `stop`  in  1  level; a rising edge pauses counting.
- `clear`  in  1  level; a rising edge aborts and zeroes the time.
- `inc_sec`  in  1  level; a rising edge presets seconds +1.
- `inc_min`  in  1  level; a rising edge presets minutes +1.
- `dir`  in  1  1 = count up, 0 = count down. Sampled only on the start edge that enters RUN.
- `min_tens`, `min_units`, `sec_tens`, `sec_units`  out  4 each  BCD time digits.
- `running`  out  1  high in RUN.
- `finished`  out  1  high in DONE.
- `finish_pulse`  out  1  one-cycle pulse on entry to DONE.
- `tick`  out  1  one-cycle pulse on every one-second step.

## Operation
- **Edge detection.** Each button has a registered previous value, reset 0. An edge is `in & ~prev`. A level held high produces exactly one edge.
- **States:** IDLE, RUN, PAUSE, DONE. Reset goes to IDLE.
- **Edge priority, same cycle:** clear > stop > start. Preset edges are evaluated independently of the state edges.
- **clear,** any state: go to IDLE, time 00:00, prescaler 0, direction latch 0.
- **start** in IDLE or PAUSE: go to RUN, latch `dir`, prescaler 0.
  - Ignored if the latched direction would be down and the time is 00:00.
  - Ignored if the direction would be up and the time is MAX_MIN:59.
  - Ignored in RUN and DONE.
- **stop** in RUN: go to PAUSE; prescaler and time are held. Ignored elsewhere.
- **Presets,** honoured only in IDLE and PAUSE.
  - inc_sec: seconds go 00→59 then wrap to 00; no carry into minutes.
  - inc_min: minutes go 00→MAX_MIN then wrap to 00.
  - Simultaneous inc_sec and inc_min both apply.
  - Presets are ignored in RUN and DONE, and in the cycle a start edge is accepted.
- **RUN.**
  - The prescaler counts 0..CYCLES_PER_SEC-1. At terminal count it returns to 0 and a step occurs.
  - Down step: decrement with BCD borrow (sec_units → sec_tens 5 → min_units → min_tens).
  - Up step: increment with BCD carry (seconds wrap at 59 into minutes).
  - A down step that produces 00:00, or an up step that produces MAX_MIN:59, moves to DONE in the same edge.
- **DONE.** Time frozen, `finished`=1. Only clear or reset leaves DONE.
- **Arithmetic.**
  - Digits are always valid BCD: sec_tens ≤5, and minutes never exceed MAX_MIN.
  - Prescaler width is $clog2(CYCLES_PER_SEC).

## Timing
- All outputs are registered. Reset value of every output is 0.
- A start edge sampled at edge N gives `running`=1 after edge N.
- The first step occurs at edge N+CYCLES_PER_SEC, then every CYCLES_PER_SEC edges.
- `tick` is high for the one cycle following each step edge, aligned with the updated digits.
- `finish_pulse` and `tick` are both high in the cycle `finished` first reads 1. `running` is 0 in that cycle.
- Stop at edge M freezes the prescaler at its value after edge M-1. A resume continues from prescaler 0, not from the frozen value.
- Preset edges update digits one cycle after the input rises.
- Reset mid-RUN: IDLE and 00:00 after that edge; no `finish_pulse` or `tick`.
- Clear in the same cycle as a terminal-count step: clear wins; no `tick` and no DONE.

## Test plan
All scenarios use CYCLES_PER_SEC=4 and MAX_MIN=99.

1. **Preset and count down.** Reset, then 2× inc_min, 1× inc_sec (02:01), dir=0, start.
   - Digits read 02:00 after 4 cycles and 01:59 after 8.
   - 00:00 and DONE after 121×4 cycles, with `finish_pulse` high for one cycle.
2. **Count up to the limit.** Preset 99:58, dir=1, start.
   - 99:59 after 4 cycles, then `finished`=1.
   - A further start edge leaves the state unchanged.
3. **Pause and resume.** Running down from 00:10, stop after 6 cycles (time 00:09), hold 20 cycles, restart.
   - No `tick` while paused.
   - Next step is exactly 4 cycles after the restart edge (00:08).
4. **Wrap and ignore rules.**
   - 60 inc_sec edges from 00:00 return to 00:00 with minutes untouched.
   - 100 inc_min edges return to 00:00.
   - Preset edges during RUN leave the digits unchanged.
5. **Edge priority and held buttons.**
   - clear and start rising together from PAUSE give IDLE, 00:00.
   - start held high for 50 cycles counts as one edge.
   - A start edge in down mode at 00:00 keeps IDLE with `running`=0.
6. **Reset mid-operation.** Reset asserted in RUN at 05:30.
   - Next cycle: all outputs 0, state IDLE.
   - A subsequent start at 00:00 in down mode is ignored.

Source files
------------

// File: rtl/bcd_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_timer_core
//  Purpose  : MM:SS timer holding four BCD digits. Counts up or down once per
//             CYCLES_PER_SEC clocks, supports pause/resume, clear and manual
//             minute/second presets, and flags completion.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             start/stop/clear       - button levels, acted on at rising edge
//             inc_sec/inc_min        - preset button levels (rising edge)
//             dir                    - 1 = up, 0 = down (latched on start)
//             min_tens..sec_units    - BCD time digits
//             running/finished       - state flags (RUN / DONE)
//             finish_pulse/tick      - one-cycle event pulses
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_timer_core #(
    parameter int CYCLES_PER_SEC = 50_000_000,
    parameter int MAX_MIN        = 99
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       dir,
    output logic [3:0] min_tens,
    output logic [3:0] min_units,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_units,
    output logic       running,
    output logic       finished,
    output logic       finish_pulse,
    output logic       tick
);

    localparam int              c_pw        = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
    localparam logic [c_pw-1:0] c_presc_tc  = c_pw'(CYCLES_PER_SEC - 1);
    localparam logic [c_pw-1:0] c_presc_one = c_pw'(1);
    localparam logic [3:0]      c_max_mt    = 4'(MAX_MIN / 10);
    localparam logic [3:0]      c_max_mu    = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Button bit positions inside the packed button vector
    localparam int c_b_start = 0;
    localparam int c_b_stop  = 1;
    localparam int c_b_clear = 2;
    localparam int c_b_isec  = 3;
    localparam int c_b_imin  = 4;

    state_t          state_q, state_d;
    logic [c_pw-1:0] presc_q, presc_d;
    logic            dir_q, dir_d;
    logic [4:0]      btn_prev_q, btn_prev_d;
    logic [3:0]      mt_q, mt_d, mu_q, mu_d, st_q, st_d, su_q, su_d;
    logic            running_q, running_d;
    logic            finished_q, finished_d;
    logic            finish_pulse_q, finish_pulse_d;
    logic            tick_q, tick_d;

    logic [4:0]      w_btn;
    logic [4:0]      w_edge;
    logic            w_time_zero;
    logic            w_time_max;
    logic            w_start_ok;
    logic [3:0]      w_step_mt, w_step_mu, w_step_st, w_step_su;
    logic            w_step_done;
    logic [3:0]      w_pre_mt, w_pre_mu, w_pre_st, w_pre_su;

    assign w_btn  = {inc_min, inc_sec, clear, stop, start};
    assign w_edge = w_btn & ~btn_prev_q;

    assign w_time_zero = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);
    assign w_time_max  = (mt_q == c_max_mt) && (mu_q == c_max_mu) && (st_q == 4'd5) && (su_q == 4'd9);

    // A start edge is refused when the requested direction has nowhere to go.
    // A simultaneous stop edge outranks start, so the start is dropped then.
    assign w_start_ok = w_edge[c_b_start] && !w_edge[c_b_stop] &&
                        (dir ? !w_time_max : !w_time_zero);

    // One-second step result in the latched direction, plus completion check
    always_comb begin
        w_step_mt = mt_q;
        w_step_mu = mu_q;
        w_step_st = st_q;
        w_step_su = su_q;
        if (dir_q) begin
            if (su_q != 4'd9) begin
                w_step_su = su_q + 4'd1;
            end else begin
                w_step_su = 4'd0;
                if (st_q != 4'd5) begin
                    w_step_st = st_q + 4'd1;
                end else begin
                    w_step_st = 4'd0;
                    if (mu_q != 4'd9) begin
                        w_step_mu = mu_q + 4'd1;
                    end else begin
                        w_step_mu = 4'd0;
                        w_step_mt = mt_q + 4'd1;
                    end
                end
            end
        end else begin
            if (su_q != 4'd0) begin
                w_step_su = su_q - 4'd1;
            end else begin
                w_step_su = 4'd9;
                if (st_q != 4'd0) begin
                    w_step_st = st_q - 4'd1;
                end else begin
                    w_step_st = 4'd5;
                    if (mu_q != 4'd0) begin
                        w_step_mu = mu_q - 4'd1;
                    end else begin
                        w_step_mu = 4'd9;
                        w_step_mt = mt_q - 4'd1;
                    end
                end
            end
        end

        if (dir_q) begin
            w_step_done = (w_step_mt == c_max_mt) && (w_step_mu == c_max_mu) &&
                          (w_step_st == 4'd5) && (w_step_su == 4'd9);
        end else begin
            w_step_done = (w_step_mt == 4'd0) && (w_step_mu == 4'd0) &&
                          (w_step_st == 4'd0) && (w_step_su == 4'd0);
        end
    end

    // Preset result: seconds and minutes wrap independently, no carry
    always_comb begin
        w_pre_mt = mt_q;
        w_pre_mu = mu_q;
        w_pre_st = st_q;
        w_pre_su = su_q;
        if (w_edge[c_b_isec]) begin
            if (st_q == 4'd5 && su_q == 4'd9) begin
                w_pre_st = 4'd0;
                w_pre_su = 4'd0;
            end else if (su_q == 4'd9) begin
                w_pre_st = st_q + 4'd1;
                w_pre_su = 4'd0;
            end else begin
                w_pre_su = su_q + 4'd1;
            end
        end
        if (w_edge[c_b_imin]) begin
            if (mt_q == c_max_mt && mu_q == c_max_mu) begin
                w_pre_mt = 4'd0;
                w_pre_mu = 4'd0;
            end else if (mu_q == 4'd9) begin
                w_pre_mt = mt_q + 4'd1;
                w_pre_mu = 4'd0;
            end else begin
                w_pre_mu = mu_q + 4'd1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d        = state_q;
        presc_d        = presc_q;
        dir_d          = dir_q;
        btn_prev_d     = w_btn;
        mt_d           = mt_q;
        mu_d           = mu_q;
        st_d           = st_q;
        su_d           = su_q;
        finish_pulse_d = 1'b0;
        tick_d         = 1'b0;

        if (w_edge[c_b_clear]) begin
            state_d = ST_IDLE;
            presc_d = '0;
            dir_d   = 1'b0;
            mt_d    = 4'd0;
            mu_d    = 4'd0;
            st_d    = 4'd0;
            su_d    = 4'd0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    if (w_start_ok) begin
                        state_d = ST_RUN;
                        dir_d   = dir;
                        presc_d = '0;
                    end else begin
                        mt_d = w_pre_mt;
                        mu_d = w_pre_mu;
                        st_d = w_pre_st;
                        su_d = w_pre_su;
                    end
                end
                ST_RUN: begin
                    if (w_edge[c_b_stop]) begin
                        state_d = ST_PAUSE;
                    end else if (presc_q == c_presc_tc) begin
                        presc_d = '0;
                        tick_d  = 1'b1;
                        mt_d    = w_step_mt;
                        mu_d    = w_step_mu;
                        st_d    = w_step_st;
                        su_d    = w_step_su;
                        if (w_step_done) begin
                            state_d        = ST_DONE;
                            finish_pulse_d = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + c_presc_one;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
            endcase
        end

        running_d  = (state_d == ST_RUN);
        finished_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            dir_q          <= 1'b0;
            btn_prev_q     <= 5'd0;
            mt_q           <= 4'd0;
            mu_q           <= 4'd0;
            st_q           <= 4'd0;
            su_q           <= 4'd0;
            running_q      <= 1'b0;
            finished_q     <= 1'b0;
            finish_pulse_q <= 1'b0;
            tick_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            presc_q        <= presc_d;
            dir_q          <= dir_d;
            btn_prev_q     <= btn_prev_d;
            mt_q           <= mt_d;
            mu_q           <= mu_d;
            st_q           <= st_d;
            su_q           <= su_d;
            running_q      <= running_d;
            finished_q     <= finished_d;
            finish_pulse_q <= finish_pulse_d;
            tick_q         <= tick_d;
        end
    end

    assign min_tens     = mt_q;
    assign min_units    = mu_q;
    assign sec_tens     = st_q;
    assign sec_units    = su_q;
    assign running      = running_q;
    assign finished     = finished_q;
    assign finish_pulse = finish_pulse_q;
    assign tick         = tick_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_timer_core
//  Purpose  : Self-checking bench for bcd_timer_core (CYCLES_PER_SEC=4,
//             MAX_MIN=99): directed scenarios plus randomized buttons checked
//             against a total-seconds reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_timer_core;

    localparam int CPS   = 4;
    localparam int MAXM  = 99;
    localparam int T_MAX = MAXM * 60 + 59;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_CLEAR = 2;
    localparam int B_SEC   = 3;
    localparam int B_MIN   = 4;

    logic       clk;
    logic       reset;
    logic       start, stop, clear, inc_sec, inc_min, dir;
    logic [3:0] min_tens, min_units, sec_tens, sec_units;
    logic       running, finished, finish_pulse, tick;

    int n_tests = 0;
    int n_fail  = 0;

    bcd_timer_core #(
        .CYCLES_PER_SEC(CPS),
        .MAX_MIN       (MAXM)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .clear       (clear),
        .inc_sec     (inc_sec),
        .inc_min     (inc_min),
        .dir         (dir),
        .min_tens    (min_tens),
        .min_units   (min_units),
        .sec_tens    (sec_tens),
        .sec_units   (sec_units),
        .running     (running),
        .finished    (finished),
        .finish_pulse(finish_pulse),
        .tick        (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] digits = {min_tens, min_units, sec_tens, sec_units};
    wire [19:0] obs    = {digits, running, finished, finish_pulse, tick};

    // ------------------------------------------------------------------
    // Reference model: time kept as a total number of seconds
    // ------------------------------------------------------------------
    int   m_t     = 0;
    int   m_state = S_IDLE;
    int   m_pre   = 0;
    bit   m_dir   = 1'b0;
    bit   m_fp    = 1'b0;
    bit   m_tick  = 1'b0;
    bit [4:0] m_prev = 5'd0;

    always @(posedge clk) begin : model
        bit [4:0] b;
        bit [4:0] e;
        int s;
        int m;
        b = {inc_min, inc_sec, clear, stop, start};
        if (reset) begin
            m_t = 0; m_state = S_IDLE; m_pre = 0; m_dir = 0;
            m_fp = 0; m_tick = 0; m_prev = 0;
        end else begin
            e = b & ~m_prev;
            m_prev = b;
            m_fp = 0;
            m_tick = 0;
            if (e[B_CLEAR]) begin
                m_t = 0; m_state = S_IDLE; m_pre = 0; m_dir = 0;
            end else if (m_state == S_IDLE || m_state == S_PAUSE) begin
                if (e[B_START] && !e[B_STOP] && (dir ? (m_t != T_MAX) : (m_t != 0))) begin
                    m_state = S_RUN; m_dir = dir; m_pre = 0;
                end else begin
                    s = m_t % 60;
                    m = m_t / 60;
                    if (e[B_SEC]) s = (s + 1) % 60;
                    if (e[B_MIN]) m = (m + 1) % (MAXM + 1);
                    m_t = m * 60 + s;
                end
            end else if (m_state == S_RUN) begin
                if (e[B_STOP]) begin
                    m_state = S_PAUSE;
                end else if (m_pre == CPS - 1) begin
                    m_pre = 0;
                    m_tick = 1;
                    m_t = m_dir ? m_t + 1 : m_t - 1;
                    if ((m_dir && m_t == T_MAX) || (!m_dir && m_t == 0)) begin
                        m_state = S_DONE;
                        m_fp = 1;
                    end
                end else begin
                    m_pre = m_pre + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_btn(input int which, input logic v);
        case (which)
            B_START: start   = v;
            B_STOP:  stop    = v;
            B_CLEAR: clear   = v;
            B_SEC:   inc_sec = v;
            default: inc_min = v;
        endcase
    endtask

    task automatic press(input int which);
        set_btn(which, 1'b1);
        cyc(1);
        set_btn(which, 1'b0);
        cyc(1);
    endtask

    task automatic do_reset();
        start = 0; stop = 0; clear = 0; inc_sec = 0; inc_min = 0; dir = 0;
        reset = 1;
        cyc(2);
        reset = 0;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", obs, 20'h0);
        end
    endtask

    task automatic test_countdown();
        do_reset();
        press(B_MIN); press(B_MIN); press(B_SEC);
        n_tests++;
        if (digits !== 16'h0201) begin
            n_fail++; $display("FAIL cd_preset: got %h expected 0201", digits);
        end
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        n_tests++;
        if (running !== 1'b1) begin
            n_fail++; $display("FAIL cd_running: got %b expected 1", running);
        end
        cyc(3);
        n_tests++;
        if ({digits, tick} !== {16'h0201, 1'b0}) begin
            n_fail++; $display("FAIL cd_before_step: got %h/%b expected 0201/0", digits, tick);
        end
        cyc(1);
        n_tests++;
        if ({digits, tick} !== {16'h0200, 1'b1}) begin
            n_fail++; $display("FAIL cd_step1: got %h/%b expected 0200/1", digits, tick);
        end
        cyc(4);
        n_tests++;
        if (digits !== 16'h0159) begin
            n_fail++; $display("FAIL cd_step2: got %h expected 0159", digits);
        end
        cyc(475);
        n_tests++;
        if ({digits, finished} !== {16'h0001, 1'b0}) begin
            n_fail++; $display("FAIL cd_pre_done: got %h/%b expected 0001/0", digits, finished);
        end
        cyc(1);
        n_tests++;
        if (obs !== {16'h0000, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++; $display("FAIL cd_done: got %h expected %h", obs, {16'h0000, 4'b0111});
        end
        cyc(1);
        n_tests++;
        if (obs !== {16'h0000, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++; $display("FAIL cd_done_hold: got %h expected %h", obs, {16'h0000, 4'b0100});
        end
    endtask

    task automatic test_count_up();
        do_reset();
        repeat (99) press(B_MIN);
        repeat (58) press(B_SEC);
        n_tests++;
        if (digits !== 16'h9958) begin
            n_fail++; $display("FAIL up_preset: got %h expected 9958", digits);
        end
        dir = 1; start = 1;
        cyc(1);
        start = 0;
        cyc(3);
        n_tests++;
        if ({digits, running} !== {16'h9958, 1'b1}) begin
            n_fail++; $display("FAIL up_running: got %h/%b expected 9958/1", digits, running);
        end
        cyc(1);
        n_tests++;
        if (obs !== {16'h9959, 4'b0111}) begin
            n_fail++; $display("FAIL up_done: got %h expected %h", obs, {16'h9959, 4'b0111});
        end
        press(B_START);
        n_tests++;
        if (obs !== {16'h9959, 4'b0100}) begin
            n_fail++; $display("FAIL up_start_in_done: got %h expected %h", obs, {16'h9959, 4'b0100});
        end
    endtask

    task automatic test_pause_resume();
        int ticks;
        do_reset();
        repeat (10) press(B_SEC);
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        cyc(5);
        stop = 1;
        cyc(1);
        stop = 0;
        n_tests++;
        if ({digits, running} !== {16'h0009, 1'b0}) begin
            n_fail++; $display("FAIL pr_paused: got %h/%b expected 0009/0", digits, running);
        end
        ticks = 0;
        repeat (20) begin
            cyc(1);
            ticks += int'(tick);
        end
        n_tests++;
        if (ticks !== 0 || digits !== 16'h0009) begin
            n_fail++; $display("FAIL pr_hold: got ticks=%0d time=%h expected 0/0009", ticks, digits);
        end
        start = 1;
        cyc(1);
        start = 0;
        cyc(3);
        n_tests++;
        if ({digits, tick, running} !== {16'h0009, 1'b0, 1'b1}) begin
            n_fail++; $display("FAIL pr_resume_early: got %h/%b/%b expected 0009/0/1", digits, tick, running);
        end
        cyc(1);
        n_tests++;
        if ({digits, tick} !== {16'h0008, 1'b1}) begin
            n_fail++; $display("FAIL pr_resume_step: got %h/%b expected 0008/1", digits, tick);
        end
    endtask

    task automatic test_wrap_ignore();
        do_reset();
        repeat (59) press(B_SEC);
        n_tests++;
        if (digits !== 16'h0059) begin
            n_fail++; $display("FAIL wr_sec59: got %h expected 0059", digits);
        end
        press(B_SEC);
        n_tests++;
        if (digits !== 16'h0000) begin
            n_fail++; $display("FAIL wr_sec_wrap: got %h expected 0000", digits);
        end
        repeat (99) press(B_MIN);
        n_tests++;
        if (digits !== 16'h9900) begin
            n_fail++; $display("FAIL wr_min99: got %h expected 9900", digits);
        end
        press(B_MIN);
        n_tests++;
        if (digits !== 16'h0000) begin
            n_fail++; $display("FAIL wr_min_wrap: got %h expected 0000", digits);
        end
        press(B_MIN);
        dir = 0; start = 1;
        cyc(1);
        start = 0; inc_sec = 1; inc_min = 1;
        cyc(1);
        inc_sec = 0; inc_min = 0;
        cyc(1);
        n_tests++;
        if (digits !== 16'h0100) begin
            n_fail++; $display("FAIL wr_preset_in_run: got %h expected 0100", digits);
        end
        cyc(2);
        n_tests++;
        if (digits !== 16'h0059) begin
            n_fail++; $display("FAIL wr_run_step: got %h expected 0059", digits);
        end
    endtask

    task automatic test_priority();
        int ticks;
        do_reset();
        repeat (5) press(B_SEC);
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        cyc(1);
        stop = 1;
        cyc(1);
        stop = 0;
        n_tests++;
        if ({digits, running} !== {16'h0005, 1'b0}) begin
            n_fail++; $display("FAIL pri_pause: got %h/%b expected 0005/0", digits, running);
        end
        clear = 1; start = 1;
        cyc(1);
        clear = 0; start = 0;
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL pri_clear_start: got %h expected %h", obs, 20'h0);
        end
        cyc(1);
        press(B_MIN);
        dir = 0; start = 1;
        cyc(1);
        ticks = 0;
        repeat (49) begin
            cyc(1);
            ticks += int'(tick);
        end
        n_tests++;
        if (ticks !== 12 || digits !== 16'h0048 || running !== 1'b1) begin
            n_fail++; $display("FAIL pri_held_start: got ticks=%0d time=%h run=%b expected 12/0048/1",
                               ticks, digits, running);
        end
        start = 0;
        press(B_CLEAR);
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL pri_start_at_zero: got %h expected %h", obs, 20'h0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        repeat (5) press(B_MIN);
        repeat (30) press(B_SEC);
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        cyc(2);
        n_tests++;
        if ({digits, running} !== {16'h0530, 1'b1}) begin
            n_fail++; $display("FAIL rm_running: got %h/%b expected 0530/1", digits, running);
        end
        reset = 1;
        cyc(1);
        reset = 0;
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL rm_reset: got %h expected %h", obs, 20'h0);
        end
        cyc(1);
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL rm_after_reset: got %h expected %h", obs, 20'h0);
        end
        dir = 0; start = 1;
        cyc(1);
        start = 0;
        n_tests++;
        if (obs !== 20'h0) begin
            n_fail++; $display("FAIL rm_start_zero: got %h expected %h", obs, 20'h0);
        end
    endtask

    task automatic test_random();
        logic [19:0] exp_v;
        int mm;
        int ss;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0)   start   = ~start;
            if ($urandom_range(0, 11) == 0)  stop    = ~stop;
            if ($urandom_range(0, 39) == 0)  clear   = ~clear;
            if ($urandom_range(0, 5) == 0)   inc_sec = ~inc_sec;
            if ($urandom_range(0, 19) == 0)  inc_min = ~inc_min;
            if ($urandom_range(0, 9) == 0)   dir     = ~dir;
            reset = ($urandom_range(0, 599) == 0);
            cyc(1);
            mm = m_t / 60;
            ss = m_t % 60;
            exp_v = {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                     m_state == S_RUN, m_state == S_DONE, m_fp, m_tick};
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        reset = 0;
    endtask

    initial begin
        reset = 1;
        start = 0; stop = 0; clear = 0; inc_sec = 0; inc_min = 0; dir = 0;
        test_reset();
        test_countdown();
        test_count_up();
        test_pause_resume();
        test_wrap_ignore();
        test_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
